// File: rtl/rx_if.sv
// UART receive-side bundle between the line/rate counter and the framing controller.
interface rx_if #(
    parameter int DATA_W = 8
);
    logic              rx_pin_in;
    logic              rx_en_sig;
    logic              bps_clk;
    logic              rx_count_sig;
    logic [DATA_W-1:0] rx_data;
    logic              rx_done_sig;
    logic              frame_err;

    modport master (
        output rx_pin_in, rx_en_sig, bps_clk,
        input  rx_count_sig, rx_data, rx_done_sig, frame_err
    );

    modport slave (
        input  rx_pin_in, rx_en_sig, bps_clk,
        output rx_count_sig, rx_data, rx_done_sig, frame_err
    );
endinterface

// File: rtl/rx_control_module.sv
// UART receive framing controller: start detect, LSB-first byte assembly,
// stop-bit check with one-cycle done / framing-error strobes.
module rx_control_module #(
    parameter int DATA_W = 8
) (
    input  logic clk,
    input  logic rst_n,
    rx_if.slave  bus
);
    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state, state_n;
    logic [CW-1:0]     bit_cnt, bit_cnt_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic [DATA_W-1:0] data_q, data_n;
    logic              count_q, count_n;
    logic              done_q, done_n;
    logic              ferr_q, ferr_n;
    logic              s1, d_sync, d_prev;
    logic              fall;

    // Synchronizer FFs reset high so a reset never looks like a start edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1     <= 1'b1;
            d_sync <= 1'b1;
            d_prev <= 1'b1;
        end else begin
            s1     <= bus.rx_pin_in;
            d_sync <= s1;
            d_prev <= d_sync;
        end
    end

    assign fall = d_prev & ~d_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            data_q  <= '0;
            count_q <= 1'b0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            shreg   <= shreg_n;
            data_q  <= data_n;
            count_q <= count_n;
            done_q  <= done_n;
            ferr_q  <= ferr_n;
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        data_n    = data_q;
        count_n   = count_q;
        done_n    = 1'b0;
        ferr_n    = 1'b0;
        if (state == IDLE) begin
            count_n = 1'b0;
            if (fall && bus.rx_en_sig) begin
                count_n   = 1'b1;
                bit_cnt_n = '0;
                state_n   = START;
            end
        end else if (!bus.rx_en_sig) begin
            count_n = 1'b0;
            state_n = IDLE;
        end else if (bus.bps_clk) begin
            unique case (state)
                START: begin
                    if (d_sync) begin
                        count_n = 1'b0;
                        state_n = IDLE;
                    end else begin
                        state_n = DATA;
                    end
                end
                DATA: begin
                    shreg_n[bit_cnt] = d_sync;
                    bit_cnt_n        = bit_cnt + 1'b1;
                    if (bit_cnt == CW'(DATA_W - 1))
                        state_n = STOP;
                end
                STOP: begin
                    count_n = 1'b0;
                    state_n = IDLE;
                    if (d_sync) begin
                        data_n = shreg;
                        done_n = 1'b1;
                    end else begin
                        ferr_n = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign bus.rx_count_sig = count_q;
    assign bus.rx_data      = data_q;
    assign bus.rx_done_sig  = done_q;
    assign bus.frame_err    = ferr_q;
endmodule

// File: tb/tb_rx_control_module.sv
// Bench for rx_control_module: bit-rate counter model, frame driver,
// strobe monitor and a frame-level scoreboard.
module tb_rx_control_module;
    localparam int BPS  = 433;
    localparam int HALF = 216;
    localparam int BIT  = BPS + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    rx_if #(.DATA_W(8)) bus();

    rx_control_module #(.DATA_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Bit-rate counter: held at 0 while rx_count_sig is low
    int unsigned rate_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    rate_cnt <= 0;
        else if (!bus.rx_count_sig)    rate_cnt <= 0;
        else if (rate_cnt == BPS)      rate_cnt <= 0;
        else                           rate_cnt <= rate_cnt + 1;
    end
    assign bus.bps_clk = bus.rx_count_sig && (rate_cnt == HALF);

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor
    logic [7:0] obs_q[$];
    int obs_ferr = 0;
    int last_evt = 0;
    int viol_both = 0, viol_width = 0, viol_cnt = 0;
    logic pd = 1'b0, pf = 1'b0;
    always @(negedge clk) begin
        if (bus.rx_done_sig && bus.frame_err) viol_both++;
        if (bus.rx_done_sig && pd) viol_width++;
        if (bus.frame_err && pf) viol_width++;
        if (bus.rx_done_sig || bus.frame_err) begin
            last_evt = cyc;
            if (bus.rx_count_sig) viol_cnt++;
        end
        if (bus.rx_done_sig) obs_q.push_back(bus.rx_data);
        if (bus.frame_err) obs_ferr++;
        pd = bus.rx_done_sig;
        pf = bus.frame_err;
    end

    // Reference model: frame-level outcomes
    logic [7:0] exp_q[$];
    int exp_ferr = 0;
    logic [7:0] exp_data = 8'h00;

    // en_mode: 0 enabled, 1 disabled whole frame, 2 enable dropped mid-frame
    task automatic send_frame(input logic [7:0] b, input bit stop,
                              input int en_mode, input int rst_bit);
        int t0;
        bit expect_evt;
        @(negedge clk);
        if (en_mode == 1) bus.rx_en_sig = 1'b0;
        bus.rx_pin_in = 1'b0;
        t0 = cyc;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.rx_pin_in = b[i];
            if (en_mode == 2 && i == 3) bus.rx_en_sig = 1'b0;
            if (rst_bit == i) begin
                repeat (200) @(negedge clk);
                rst_n = 1'b0;
                #1;
                chk("rst_data", {24'h0, bus.rx_data}, 32'h0);
                chk("rst_count", {31'h0, bus.rx_count_sig}, 32'h0);
                chk("rst_done", {31'h0, bus.rx_done_sig}, 32'h0);
                repeat (20) @(negedge clk);
                rst_n = 1'b1;
                repeat (BIT - 220) @(negedge clk);
            end else begin
                repeat (BIT) @(negedge clk);
            end
        end
        bus.rx_pin_in = stop;
        repeat (BIT) @(negedge clk);
        bus.rx_pin_in = 1'b1;
        bus.rx_en_sig = 1'b1;
        expect_evt = (en_mode == 0) && (rst_bit < 0);
        if (rst_bit >= 0) exp_data = 8'h00;
        if (expect_evt) begin
            if (stop) begin
                exp_q.push_back(b);
                exp_data = b;
            end else begin
                exp_ferr++;
            end
            // stop-bit sample lands ~9.5 bit times after the start edge
            chk("latency", {31'h0, (last_evt - t0 >= 4120) &&
                            (last_evt - t0 <= 4132)}, 32'h1);
        end
    endtask

    task automatic checkpoint(input string tag);
        int n;
        chk({tag, "_ndone"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk({tag, "_byte"}, {24'h0, obs_q[i]}, {24'h0, exp_q[i]});
        obs_q.delete();
        exp_q.delete();
        chk({tag, "_nferr"}, obs_ferr, exp_ferr);
        chk({tag, "_data"}, {24'h0, bus.rx_data}, {24'h0, exp_data});
        chk({tag, "_count"}, {31'h0, bus.rx_count_sig}, 32'h0);
    endtask

    initial begin
        logic [7:0] rb;
        bit rs;
        int rm;
        bus.rx_pin_in = 1'b1;
        bus.rx_en_sig = 1'b1;
        repeat (5) @(negedge clk);
        chk("reset_data", {24'h0, bus.rx_data}, 32'h0);
        chk("reset_count", {31'h0, bus.rx_count_sig}, 32'h0);
        chk("reset_done", {31'h0, bus.rx_done_sig}, 32'h0);
        chk("reset_ferr", {31'h0, bus.frame_err}, 32'h0);
        rst_n = 1'b1;
        repeat (1000) @(negedge clk);
        checkpoint("idle");

        send_frame(8'hA5, 1'b1, 0, -1);
        repeat (200) @(negedge clk);
        checkpoint("a5");

        bus.rx_pin_in = 1'b0;
        repeat (50) @(negedge clk);
        chk("glitch_count_on", {31'h0, bus.rx_count_sig}, 32'h1);
        repeat (50) @(negedge clk);
        bus.rx_pin_in = 1'b1;
        repeat (600) @(negedge clk);
        checkpoint("glitch");

        send_frame(8'h3C, 1'b0, 0, -1);
        repeat (200) @(negedge clk);
        checkpoint("ferr");

        send_frame(8'h00, 1'b1, 0, -1);
        send_frame(8'hFF, 1'b1, 0, -1);
        send_frame(8'h55, 1'b1, 1, -1);
        repeat (200) @(negedge clk);
        checkpoint("b2b");

        send_frame(8'h66, 1'b1, 2, -1);
        repeat (200) @(negedge clk);
        checkpoint("abort");

        send_frame(8'hF3, 1'b1, 0, 4);
        repeat (200) @(negedge clk);
        checkpoint("rst_mid");
        send_frame(8'h5A, 1'b1, 0, -1);
        repeat (200) @(negedge clk);
        checkpoint("5a");

        for (int k = 0; k < 5; k++) begin
            rb = 8'($urandom);
            rs = ($urandom_range(0, 3) != 0);
            rm = ($urandom_range(0, 4) < 3) ? 0 : int'($urandom_range(1, 2));
            send_frame(rb, rs, rm, -1);
            repeat ($urandom_range(1, 100)) @(negedge clk);
            checkpoint("rand");
        end

        chk("never_both", viol_both, 0);
        chk("one_cycle", viol_width, 0);
        chk("count_drop", viol_cnt, 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
